// File: rtl/bp_cce_pkg.sv
// rtl/bp_cce_pkg.sv - CCE directory opcodes and segment FSM states
package bp_cce_pkg;

    typedef enum logic [2:0] {
        e_rdw = 3'd0,
        e_rde = 3'd1,
        e_wds = 3'd2,
        e_wde = 3'd3,
        e_clr = 3'd4
    } bp_cce_dir_op_e;

    typedef enum logic [2:0] {
        e_init,
        e_ready,
        e_rd_row,
        e_clr_row,
        e_resp
    } bp_cce_dir_state_e;

endpackage

// File: rtl/bp_common_pkg.sv
// rtl/bp_common_pkg.sv - shared coherence state encoding
package bp_common_pkg;

    // Invalid must stay at zero: a zeroed directory entry reads as invalid
    typedef enum logic [2:0] {
        e_COH_I = 3'd0,
        e_COH_S = 3'd1,
        e_COH_E = 3'd2,
        e_COH_F = 3'd3,
        e_COH_M = 3'd4,
        e_COH_O = 3'd5
    } bp_coh_states_e;

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_bit.sv
// rtl/bsg_mem_1rw_sync_mask_write_bit.sv - single-port sync RAM with per-bit write mask
module bsg_mem_1rw_sync_mask_write_bit #(
    parameter int width_p = 8,
    parameter int els_p   = 16,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem [els_p];

    // Masked write merges new bits into the row; a read returns data the next cycle
    always_ff @(posedge clk_i) begin
        if (v_i && w_i)
            mem[addr_i] <= (mem[addr_i] & ~w_mask_i) | (data_i & w_mask_i);
        if (v_i && !w_i)
            data_o <= mem[addr_i];
    end

endmodule

// File: rtl/bp_cce_dir_segment_seq.sv
// rtl/bp_cce_dir_segment_seq.sv - multi-cycle directory segment for one LCE type
module bp_cce_dir_segment_seq
    import bp_common_pkg::*;
    import bp_cce_pkg::*;
#(
    parameter int sets_p               = 64,
    parameter int assoc_p              = 8,
    parameter int num_lce_p            = 4,
    parameter int lce_per_row_p        = 2,
    parameter int num_cce_p            = 1,
    parameter int paddr_width_p        = 40,
    parameter int block_offset_width_p = 6,
    localparam int lg_lce_lp   = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
    localparam int lg_assoc_lp = (assoc_p > 1) ? $clog2(assoc_p) : 1,
    localparam int coh_w_lp    = $bits(bp_coh_states_e)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [paddr_width_p-1:0]          addr_i,
    input  logic [lg_lce_lp-1:0]              lce_i,
    input  logic [lg_assoc_lp-1:0]            way_i,
    input  logic [lg_assoc_lp-1:0]            lru_way_i,
    input  bp_coh_states_e                    coh_state_i,
    input  bp_cce_dir_op_e                    cmd_i,
    input  logic                              v_i,
    output logic                              ready_o,
    output logic                              sharers_v_o,
    output logic [num_lce_p-1:0]              sharers_hits_o,
    output logic [num_lce_p*lg_assoc_lp-1:0]  sharers_ways_o,
    output logic [num_lce_p*coh_w_lp-1:0]     sharers_coh_states_o,
    output logic                              lru_v_o,
    output logic                              lru_cached_excl_o,
    output logic [paddr_width_p-1:0]          lru_addr_o,
    output logic                              addr_v_o,
    output logic [paddr_width_p-1:0]          addr_o
);

    localparam int rows_lp    = (num_lce_p + lce_per_row_p - 1) / lce_per_row_p;
    localparam int tag_w_lp   = paddr_width_p - block_offset_width_p;
    localparam int entry_w_lp = tag_w_lp + coh_w_lp;
    localparam int row_w_lp   = lce_per_row_p * assoc_p * entry_w_lp;
    localparam int els_lp     = sets_p * rows_lp;
    localparam int ram_aw_lp  = (els_lp > 1) ? $clog2(els_lp) : 1;
    localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1;
    localparam int lg_cce_lp  = $clog2(num_cce_p);
    localparam int row_cw_lp  = (rows_lp > 1) ? $clog2(rows_lp) : 1;

    bp_cce_dir_state_e state_q, state_n;
    bp_cce_dir_op_e    cmd_q;
    bp_coh_states_e    coh_q;
    logic [tag_w_lp-1:0]    tag_q;
    logic [lg_sets_lp-1:0]  set_q;
    logic [lg_lce_lp-1:0]   lce_q;
    logic [lg_assoc_lp-1:0] way_q, lru_way_q, sel_way;
    logic [row_cw_lp-1:0]   row_q, row_sel, rd_row_q, lce_row;
    logic [ram_aw_lp-1:0]   init_q, ram_addr;
    logic                   rd_v_q, ram_v, ram_w, accept;
    logic [row_w_lp-1:0]    ram_wdata, ram_wmask, ram_rdata;
    logic [entry_w_lp-1:0]  entry, sel_entry_acc, sel_entry_nxt;
    logic [num_lce_p-1:0]                   hits_acc, hits_nxt;
    logic [num_lce_p-1:0][lg_assoc_lp-1:0]  ways_acc, ways_nxt;
    logic [num_lce_p-1:0][coh_w_lp-1:0]     states_acc, states_nxt;
    int                     lce_slot;
    logic                   unused_offset_bits;

    assign unused_offset_bits = ^addr_i[block_offset_width_p-1:0];
    assign accept   = (state_q == e_ready) && v_i;
    assign sel_way  = (cmd_q == e_rde) ? way_q : lru_way_q;
    assign lce_row  = row_cw_lp'(int'(lce_q) / lce_per_row_p);
    assign lce_slot = int'(lce_q) % lce_per_row_p;
    assign ram_addr = (state_q == e_init) ? init_q
                    : ram_aw_lp'(set_q) * ram_aw_lp'(rows_lp) + ram_aw_lp'(row_sel);

    // FSM state register; reset restarts the init sweep from any state
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= e_init;
        else            state_q <= state_n;
    end

    // Next state and RAM port control; RDE and single-entry writes touch only the LCE's row
    always_comb begin
        state_n = state_q;
        ready_o = 1'b0;
        ram_v   = 1'b0;
        ram_w   = 1'b0;
        row_sel = row_q;
        case (state_q)
            e_init: begin
                ram_v = 1'b1;
                ram_w = 1'b1;
                if (init_q == ram_aw_lp'(els_lp - 1)) state_n = e_ready;
            end
            e_ready: begin
                ready_o = 1'b1;
                if (v_i) begin
                    case (cmd_i)
                        e_rdw, e_rde:        state_n = e_rd_row;
                        e_wds, e_wde, e_clr: state_n = e_clr_row;
                        default:             state_n = e_ready;
                    endcase
                end
            end
            e_rd_row: begin
                ram_v = 1'b1;
                if (cmd_q == e_rde) begin
                    row_sel = lce_row;
                    state_n = e_resp;
                end else if (row_q == row_cw_lp'(rows_lp - 1)) begin
                    state_n = e_resp;
                end
            end
            e_clr_row: begin
                ram_v = 1'b1;
                ram_w = 1'b1;
                if (cmd_q != e_clr) begin
                    row_sel = lce_row;
                    state_n = e_ready;
                end else if (row_q == row_cw_lp'(rows_lp - 1)) begin
                    state_n = e_ready;
                end
            end
            e_resp:  state_n = e_ready;
            default: state_n = e_init;
        endcase
    end

    // Write data and mask: init clears whole rows, CLR clears only populated slots
    always_comb begin
        ram_wdata = '0;
        ram_wmask = '0;
        if (state_q == e_init) begin
            ram_wmask = '1;
        end else begin
            for (int s = 0; s < lce_per_row_p; s++) begin
                for (int w = 0; w < assoc_p; w++) begin
                    if (cmd_q == e_clr) begin
                        if (int'(row_q) * lce_per_row_p + s < num_lce_p)
                            ram_wmask[(s*assoc_p+w)*entry_w_lp +: entry_w_lp] = '1;
                    end else if (s == lce_slot && w == int'(way_q)) begin
                        ram_wdata[(s*assoc_p+w)*entry_w_lp +: entry_w_lp] = {tag_q, coh_q};
                        ram_wmask[(s*assoc_p+w)*entry_w_lp +: entry_w_lp] =
                            (cmd_q == e_wde) ? {entry_w_lp{1'b1}}
                                             : {{tag_w_lp{1'b0}}, {coh_w_lp{1'b1}}};
                    end
                end
            end
        end
    end

    // Fold the returned row into the accumulators; descending way scan leaves the lowest hit
    always_comb begin
        hits_nxt      = hits_acc;
        ways_nxt      = ways_acc;
        states_nxt    = states_acc;
        sel_entry_nxt = sel_entry_acc;
        entry         = '0;
        if (rd_v_q) begin
            for (int l = 0; l < num_lce_p; l++) begin
                if (l / lce_per_row_p == int'(rd_row_q)) begin
                    for (int w = assoc_p - 1; w >= 0; w--) begin
                        entry = ram_rdata[((l % lce_per_row_p)*assoc_p + w)*entry_w_lp +: entry_w_lp];
                        if (entry[entry_w_lp-1 -: tag_w_lp] == tag_q && entry[coh_w_lp-1:0] != e_COH_I) begin
                            hits_nxt[l]   = 1'b1;
                            ways_nxt[l]   = lg_assoc_lp'(w);
                            states_nxt[l] = entry[coh_w_lp-1:0];
                        end
                        if (l == int'(lce_q) && w == int'(sel_way))
                            sel_entry_nxt = entry;
                    end
                end
            end
        end
    end

    // Command capture, row/init counters, read tracking and accumulators
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_q <= e_rdw;  coh_q <= e_COH_I;  tag_q <= '0;  set_q <= '0;
            lce_q <= '0;  way_q <= '0;  lru_way_q <= '0;  row_q <= '0;  init_q <= '0;
            rd_v_q <= 1'b0;  rd_row_q <= '0;
            hits_acc <= '0;  ways_acc <= '0;  states_acc <= '0;  sel_entry_acc <= '0;
        end else begin
            rd_v_q   <= ram_v && !ram_w;
            rd_row_q <= row_sel;
            if (state_q == e_init) init_q <= init_q + 1'b1;
            if (accept) begin
                cmd_q     <= cmd_i;
                coh_q     <= coh_state_i;
                tag_q     <= addr_i[paddr_width_p-1:block_offset_width_p];
                set_q     <= addr_i[block_offset_width_p+lg_cce_lp +: lg_sets_lp];
                lce_q     <= lce_i;
                way_q     <= way_i;
                lru_way_q <= lru_way_i;
                row_q     <= '0;
                hits_acc  <= '0;  ways_acc <= '0;  states_acc <= '0;  sel_entry_acc <= '0;
            end else begin
                if (state_q == e_rd_row || state_q == e_clr_row) row_q <= row_q + 1'b1;
                if (state_q == e_rd_row) begin
                    hits_acc      <= hits_nxt;
                    ways_acc      <= ways_nxt;
                    states_acc    <= states_nxt;
                    sel_entry_acc <= sel_entry_nxt;
                end
            end
        end
    end

    // Result registers: data holds between reads, valids pulse for one cycle
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sharers_v_o <= 1'b0;  sharers_hits_o <= '0;  sharers_ways_o <= '0;
            sharers_coh_states_o <= '0;  lru_v_o <= 1'b0;  lru_cached_excl_o <= 1'b0;
            lru_addr_o <= '0;  addr_v_o <= 1'b0;  addr_o <= '0;
        end else begin
            sharers_v_o <= (state_q == e_resp) && (cmd_q == e_rdw);
            lru_v_o     <= (state_q == e_resp) && (cmd_q == e_rdw);
            addr_v_o    <= (state_q == e_resp) && (cmd_q == e_rde);
            if (state_q == e_resp && cmd_q == e_rdw) begin
                sharers_hits_o       <= hits_nxt;
                sharers_ways_o       <= ways_nxt;
                sharers_coh_states_o <= states_nxt;
                lru_cached_excl_o    <= (sel_entry_nxt[coh_w_lp-1:0] == e_COH_E)
                                     || (sel_entry_nxt[coh_w_lp-1:0] == e_COH_M);
                lru_addr_o <= {sel_entry_nxt[entry_w_lp-1 -: tag_w_lp], {block_offset_width_p{1'b0}}};
            end
            if (state_q == e_resp && cmd_q == e_rde)
                addr_o <= {sel_entry_nxt[entry_w_lp-1 -: tag_w_lp], {block_offset_width_p{1'b0}}};
        end
    end

    bsg_mem_1rw_sync_mask_write_bit #(
        .width_p (row_w_lp),
        .els_p   (els_lp)
    ) dir_ram (
        .clk_i    (clk_i),
        .v_i      (ram_v),
        .w_i      (ram_w),
        .addr_i   (ram_addr),
        .data_i   (ram_wdata),
        .w_mask_i (ram_wmask),
        .data_o   (ram_rdata)
    );

    // Undefined opcodes are absorbed as no-ops but indicate a requester bug
    undefined_cmd_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (v_i && ready_o) |-> (cmd_i inside {e_rdw, e_rde, e_wds, e_wde, e_clr}));

endmodule

// File: tb/tb_bp_cce_dir_segment_seq.sv
// tb/tb_bp_cce_dir_segment_seq.sv - directed self-checking bench for bp_cce_dir_segment_seq
module tb_bp_cce_dir_segment_seq;
    import bp_common_pkg::*;
    import bp_cce_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [39:0] addr = '0;
    logic [1:0]  lce = '0;
    logic [2:0]  way = '0, lru_way = '0;
    bp_coh_states_e coh = e_COH_I;
    bp_cce_dir_op_e cmd = e_rdw;
    logic v = 1'b0;
    logic ready, sharers_v, lru_v, lru_excl, addr_v;
    logic [3:0]  hits;
    logic [11:0] ways, states;
    logic [39:0] lru_addr, addr_out;

    int checks = 0;
    int errors = 0;
    int sv_cnt = 0;
    int av_cnt = 0;
    int n, lat, w, sv0, av0;

    localparam logic [39:0] a1 = 40'h00_8000_0040;
    localparam logic [39:0] a2 = 40'h12_3456_7880;
    localparam logic [39:0] a3 = 40'h01_0000_0040;

    always #5 clk = ~clk;

    bp_cce_dir_segment_seq #(
        .sets_p(64), .assoc_p(8), .num_lce_p(4), .lce_per_row_p(2),
        .num_cce_p(1), .paddr_width_p(40), .block_offset_width_p(6)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .addr_i(addr), .lce_i(lce), .way_i(way),
        .lru_way_i(lru_way), .coh_state_i(coh), .cmd_i(cmd), .v_i(v), .ready_o(ready),
        .sharers_v_o(sharers_v), .sharers_hits_o(hits), .sharers_ways_o(ways),
        .sharers_coh_states_o(states), .lru_v_o(lru_v), .lru_cached_excl_o(lru_excl),
        .lru_addr_o(lru_addr), .addr_v_o(addr_v), .addr_o(addr_out)
    );

    always @(posedge clk) begin
        if (sharers_v) sv_cnt <= sv_cnt + 1;
        if (addr_v)    av_cnt <= av_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input bp_cce_dir_op_e c, input logic [39:0] a, input logic [1:0] l,
                        input logic [2:0] wy, input logic [2:0] lw, input bp_coh_states_e s,
                        output int waited);
        cmd = c; addr = a; lce = l; way = wy; lru_way = lw; coh = s; v = 1'b1;
        waited = 0;
        while (!ready && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!ready) check("send_ready", 64'(ready), 64'd1);
        @(posedge clk); #1;
        v = 1'b0;
    endtask

    task automatic wait_pulse(input int which, output int latency);
        latency = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if ((which == 0 && sharers_v) || (which == 1 && addr_v)) begin
                latency = k;
                break;
            end
        end
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!ready && cycles < 300) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_sharers_v", 64'(sharers_v), 64'd0);
        check("rst_lru_v", 64'(lru_v), 64'd0);
        check("rst_addr_v", 64'(addr_v), 64'd0);
        check("rst_hits", 64'(hits), 64'd0);
        check("rst_lru_addr", 64'(lru_addr), 64'd0);
        check("rst_addr_o", 64'(addr_out), 64'd0);
        check("rst_lru_excl", 64'(lru_excl), 64'd0);

        rst_n = 1'b1;
        wait_init(n);
        check("init_cycles", 64'(n), 64'd128);

        send(e_rdw, 40'h0, 2'd0, 3'd0, 3'd0, e_COH_I, w);
        check("rdw0_wait", 64'(w), 64'd0);
        wait_pulse(0, lat);
        check("rdw0_lat", 64'(lat), 64'd3);
        check("rdw0_lru_v", 64'(lru_v), 64'd1);
        check("rdw0_hits", 64'(hits), 64'd0);

        send(e_wde, a1, 2'd3, 3'd5, 3'd0, e_COH_M, w);
        check("wde_busy", 64'(ready), 64'd0);
        @(posedge clk); #1;
        check("wde_ready_back", 64'(ready), 64'd1);

        send(e_rdw, a1, 2'd3, 3'd0, 3'd5, e_COH_I, w);
        wait_pulse(0, lat);
        check("rdw1_lat", 64'(lat), 64'd3);
        check("rdw1_lru_v", 64'(lru_v), 64'd1);
        check("rdw1_hits", 64'(hits), 64'h8);
        check("rdw1_way3", 64'(ways[11:9]), 64'd5);
        check("rdw1_state3", 64'(states[11:9]), 64'd4);
        check("rdw1_excl", 64'(lru_excl), 64'd1);
        check("rdw1_lru_addr", 64'(lru_addr), 64'h80000040);

        send(e_wds, a1, 2'd3, 3'd5, 3'd0, e_COH_S, w);
        send(e_rde, a1, 2'd3, 3'd5, 3'd0, e_COH_I, w);
        wait_pulse(1, lat);
        check("rde_lat", 64'(lat), 64'd2);
        check("rde_addr", 64'(addr_out), 64'h80000040);
        check("rde_hits_held", 64'(hits), 64'h8);

        send(e_rdw, a1, 2'd3, 3'd0, 3'd5, e_COH_I, w);
        wait_pulse(0, lat);
        check("rdw2_lat", 64'(lat), 64'd3);
        check("rdw2_excl", 64'(lru_excl), 64'd0);
        check("rdw2_state3", 64'(states[11:9]), 64'd1);
        check("rdw2_hits", 64'(hits), 64'h8);

        send(e_wde, a1, 2'd3, 3'd2, 3'd0, e_COH_S, w);
        send(e_wde, a1, 2'd0, 3'd7, 3'd0, e_COH_E, w);
        send(e_rdw, a1, 2'd0, 3'd0, 3'd7, e_COH_I, w);
        wait_pulse(0, lat);
        check("rdw3_hits", 64'(hits), 64'h9);
        check("rdw3_way3_lowest", 64'(ways[11:9]), 64'd2);
        check("rdw3_way0", 64'(ways[2:0]), 64'd7);
        check("rdw3_state0", 64'(states[2:0]), 64'd2);
        check("rdw3_excl", 64'(lru_excl), 64'd1);

        send(e_rdw, a3, 2'd3, 3'd0, 3'd5, e_COH_I, w);
        wait_pulse(0, lat);
        check("rdw_other_tag_hits", 64'(hits), 64'd0);
        check("rdw_other_tag_lru_addr", 64'(lru_addr), 64'h80000040);
        check("rdw_other_tag_excl", 64'(lru_excl), 64'd0);

        send(e_clr, a1, 2'd0, 3'd0, 3'd0, e_COH_I, w);
        n = 0;
        while (!ready && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        check("clr_busy", 64'(n), 64'd2);
        send(e_rdw, a1, 2'd3, 3'd0, 3'd5, e_COH_I, w);
        wait_pulse(0, lat);
        check("clr_rdw_hits", 64'(hits), 64'd0);
        check("clr_rdw_lru_addr", 64'(lru_addr), 64'd0);

        send(e_wde, a2, 2'd1, 3'd0, 3'd0, e_COH_F, w);
        sv0 = sv_cnt;
        av0 = av_cnt;
        send(e_rdw, a2, 2'd1, 3'd0, 3'd0, e_COH_I, w);
        send(e_rde, a2, 2'd1, 3'd0, 3'd0, e_COH_I, w);
        check("hs_wait", 64'(w), 64'd3);
        repeat (6) @(posedge clk);
        #1;
        check("hs_sharers_pulses", 64'(sv_cnt - sv0), 64'd1);
        check("hs_addr_pulses", 64'(av_cnt - av0), 64'd1);
        check("hs_hits", 64'(hits), 64'h2);
        check("hs_state1", 64'(states[5:3]), 64'd3);
        check("hs_lru_addr", 64'(lru_addr), 64'h1234567880);
        check("hs_addr", 64'(addr_out), 64'h1234567880);

        sv0 = sv_cnt;
        send(e_rdw, a2, 2'd1, 3'd0, 3'd0, e_COH_I, w);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_hits", 64'(hits), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init(n);
        check("midrst_init_cycles", 64'(n), 64'd128);
        check("midrst_no_pulse", 64'(sv_cnt - sv0), 64'd0);
        send(e_rdw, a2, 2'd1, 3'd0, 3'd0, e_COH_I, w);
        wait_pulse(0, lat);
        check("midrst_rdw_lat", 64'(lat), 64'd3);
        check("midrst_rdw_hits", 64'(hits), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_cce_dir_segment_seq.md
# bp_cce_dir_segment_seq

Sequential, parametrised directory segment for the CCE. It tracks coherence state and tags for `num_lce_p` LCEs of one cache type, stored in a single-port synchronous masked-write RAM. Each RAM row holds `lce_per_row_p` LCEs' ways, so one way-group read takes multiple cycles. The block adds a self-initialising reset sweep, a multi-cycle way-group clear, and a valid/ready command handshake in place of a bare busy flag. It is the building block instantiated once per LCE type inside the CCE directory.

## Interface
- `sets_p`, 64: directory sets tracked by this CCE.
- `assoc_p`, 8: ways per LCE set.
- `num_lce_p`, 4: LCEs tracked.
- `lce_per_row_p`, 2: LCEs per RAM row. Rows per way-group `R = ceil(num_lce_p/lce_per_row_p)`.
- `num_cce_p`, 1: CCE interleave factor.
- `paddr_width_p`, 40: physical address width.
- `block_offset_width_p`, 6: log2 of block bytes. Tag width `T = paddr_width_p - block_offset_width_p`.
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `addr_i` in `paddr_width_p`: request address. Set index = `addr_i[block_offset_width_p+log2(num_cce_p) +: log2(sets_p)]`. Tag = `addr_i[paddr_width_p-1:block_offset_width_p]`.
- `lce_i` in `log2(num_lce_p)`: target LCE.
- `way_i` in `log2(assoc_p)`: target way.
- `lru_way_i` in `log2(assoc_p)`: requester LRU way, used by RDW.
- `coh_state_i` in `bp_coh_states_e`: state to write.
- `cmd_i` in `bp_cce_dir_op_e`: operation.
- `v_i` in 1: command valid.
- `ready_o` out 1: command accepted when `v_i & ready_o`.
- `sharers_v_o` out 1: one-cycle pulse; the sharers vectors are valid.
- `sharers_hits_o` out `num_lce_p`: per-LCE tag hit.
- `sharers_ways_o` out `num_lce_p x log2(assoc_p)`: hit way per LCE.
- `sharers_coh_states_o` out `num_lce_p x bp_coh_states_e`: hit state per LCE.
- `lru_v_o` out 1: one-cycle pulse; LRU info is valid.
- `lru_cached_excl_o` out 1: LRU entry state is E or M.
- `lru_addr_o` out `paddr_width_p`: LRU entry block address. Offset bits are zero.
- `addr_v_o` out 1: one-cycle pulse; RDE result is valid.
- `addr_o` out `paddr_width_p`: RDE entry block address.

## Operation
- Entry format: `{tag[T], state}`. Invalid state encodes as 0.
- FSM states and transitions:
  - `e_init` walks all `sets_p*R` rows, writing zero, then goes to `e_ready`.
  - `e_ready` accepts a command.
  - `e_rd_row` issues RAM row reads `0..R-1`.
  - `e_clr_row` writes zero to rows `0..R-1` of the set.
  - `e_resp` drives the output pulses, then returns to `e_ready`.
- Command and address fields are registered at acceptance.
- `e_rdw` (read way-group):
  - Each returned row is compared against the tag. A hit requires a matching tag and a non-invalid state.
  - For each LCE, the lowest hitting way is reported.
  - The entry at (`lce_i`, `lru_way_i`) feeds the LRU outputs.
  - `sharers_v_o` and `lru_v_o` pulse together.
- `e_rde`: reads one row and outputs the `{tag, set}` address of (`lce_i`, `way_i`) on `addr_o`.
- `e_wds`: masked write of the state field only.
- `e_wde`: masked write of tag and state.
- `e_clr`: zeroes the whole way-group of the set.
- Sharers, LRU and addr data outputs hold until the next RDW or RDE completes. Only the `*_v_o` signals pulse.
- An undefined `cmd_i` is accepted and treated as a no-op. A non-synth assertion flags it.

## Timing
- Reset values: every output is 0 and the FSM is in `e_init`.
- Reset has effect immediately on assertion. `ready_o` rises exactly `sets_p*R` cycles after deassertion.
- Reset during any operation aborts it, discards the result, and restarts the init sweep.
- Latency is counted from the acceptance edge. The pulse appears in the listed cycle.
  - RDW: `R+1`.
  - RDE: 2.
  - WDS/WDE: `ready_o` is low for 1 cycle; the write is visible to a read accepted the next cycle.
  - CLR: `ready_o` is low for `R` cycles.
- `ready_o` is low from acceptance until the cycle after the last row or response. Back-to-back commands are otherwise allowed.
- `v_i` while `ready_o` is low is ignored. The requester must hold the command.
- When `num_lce_p` is not a multiple of `lce_per_row_p`, the unused slots of the last row are never reported and never written.

## Structure
- `bp_cce_pkg` holds `bp_cce_dir_op_e` (`e_rdw`, `e_rde`, `e_wds`, `e_wde`, `e_clr`) and the FSM state enum.
- `bp_common_pkg` holds `bp_coh_states_e`.
- RAM sub-module: `bsg_mem_1rw_sync_mask_write_bit`, width `lce_per_row_p*assoc_p*(T+3)`, depth `sets_p*R`.
- Row compare logic lives in this module. No further sub-modules.

## Test plan
- Reset: release reset with `sets_p=64`, `R=2`. Required: `ready_o` is 0 for 128 cycles then 1. An RDW on any address returns `sharers_hits_o=0`.
- WDE then RDW: WDE lce 3, way 5, addr `0x8000_0040`, state M. Then RDW on the same addr with `lru_way_i=5`, `lce_i=3`. Required: `sharers_v_o` at cycle 3, hits=`4'b1000`, ways[3]=5, `lru_cached_excl_o=1`, `lru_addr_o=0x8000_0040`.
- WDS downgrade: WDS lce 3, way 5, state S, then RDE. Required: `addr_v_o` at cycle 2 with `addr_o=0x8000_0040`. A following RDW gives `lru_cached_excl_o=0`.
- CLR: CLR on that set. Required: `ready_o` is low for 2 cycles. A subsequent RDW gives hits=0.
- Handshake: hold `v_i` across a busy RDW. Required: the second command is accepted only when `ready_o` is 1, and one result is produced per command.
- Reset mid-RDW: assert `reset_n_i` during `e_rd_row`. Required: no `sharers_v_o` pulse, and the init sweep restarts.
